// File: rtl/inst_loader_pkg.sv
// Shared definitions for the instruction memory loader.
// Contents:
//   state_t     - loader FSM states
//   WORD_BYTES  - bytes per instruction word
//   LEN_BYTES   - bytes in the length header that precedes the image
package inst_loader_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LEN_LO = 3'd1,
    LEN_HI = 3'd2,
    DATA   = 3'd3,
    FLUSH  = 3'd4,
    DONE   = 3'd5,
    ERR    = 3'd6
  } state_t;

  localparam int WORD_BYTES = 4;
  localparam int LEN_BYTES  = 2;

endpackage

// File: rtl/byte_word_packer.sv
// Packs little-endian bytes into 32-bit words.
// Ports:
//   CLK, RST      clock, synchronous active-high reset
//   i_clr         synchronous clear of byte counter and partial word
//   i_byte_valid  a byte is accepted this cycle
//   i_byte        the byte
//   o_word_valid  combinational: high on the cycle the 4th byte is accepted
//   o_word        assembled word (valid with o_word_valid)
module byte_word_packer
  import inst_loader_pkg::*;
(
  input  logic        CLK,
  input  logic        RST,
  input  logic        i_clr,
  input  logic        i_byte_valid,
  input  logic [7:0]  i_byte,
  output logic        o_word_valid,
  output logic [31:0] o_word
);

  logic [1:0]  r_cnt;
  logic [23:0] r_shift;

  // Bytes enter at the top and shift down, so after three bytes the first
  // one sits in the lowest lane; the fourth byte completes the top lane.
  always_ff @(posedge CLK) begin
    if (RST || i_clr) begin
      r_cnt   <= 2'd0;
      r_shift <= 24'd0;
    end else if (i_byte_valid) begin
      r_cnt   <= r_cnt + 2'd1;
      r_shift <= {i_byte, r_shift[23:8]};
    end
  end

  assign o_word_valid = i_byte_valid && (r_cnt == 2'(WORD_BYTES - 1));
  assign o_word       = {i_byte, r_shift};

endmodule

// File: rtl/inst_mem_loader.sv
// Instruction memory loader: receives a length-prefixed byte stream, writes
// 32-bit words to instruction memory at byte addresses 0, 4, 8, ... and holds
// the CPU in reset until the whole image is written.
// Ports:
//   CLK, RST             clock, synchronous active-high reset
//   start                pulse; begins a load from IDLE or DONE
//   byte_valid/byte_data stream input, accepted when byte_ready is high
//   byte_ready           loader accepts a byte this cycle
//   mem_we/mem_waddr/mem_wdata  registered one-cycle word write
//   cpu_rst              high holds the CPU in reset
//   done                 image fully written
//   err                  length exceeded DEPTH_WORDS (sticky until RST)
module inst_mem_loader
  import inst_loader_pkg::*;
#(
  parameter int DEPTH_WORDS = 64,
  parameter int ADDR_W      = 32
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              start,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  output logic              byte_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_waddr,
  output logic [31:0]       mem_wdata,
  output logic              cpu_rst,
  output logic              done,
  output logic              err
);

  state_t             r_state;
  state_t             w_state_next;
  logic [15:0]        r_len;
  logic [15:0]        r_word_idx;
  logic               r_mem_we;
  logic [ADDR_W-1:0]  r_mem_waddr;
  logic [31:0]        r_mem_wdata;

  logic               w_accept;
  logic               w_load_start;
  logic [15:0]        w_len_full;
  logic               w_pack_valid;
  logic               w_word_valid;
  logic [31:0]        w_word;

  assign w_accept     = byte_valid && byte_ready;
  assign w_load_start = start && (r_state == IDLE || r_state == DONE);
  assign w_pack_valid = w_accept && (r_state == DATA);
  // Full length as it will be once the high byte currently on the bus lands.
  assign w_len_full   = {byte_data, r_len[7:0]};

  byte_word_packer u_packer (
    .CLK          (CLK),
    .RST          (RST),
    .i_clr        (w_load_start),
    .i_byte_valid (w_pack_valid),
    .i_byte       (byte_data),
    .o_word_valid (w_word_valid),
    .o_word       (w_word)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    byte_ready   = 1'b0;
    cpu_rst      = 1'b1;
    done         = 1'b0;
    err          = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (start) w_state_next = LEN_LO;
      end
      LEN_LO: begin
        byte_ready = 1'b1;
        if (byte_valid) w_state_next = LEN_HI;
      end
      LEN_HI: begin
        byte_ready = 1'b1;
        if (byte_valid) begin
          if (w_len_full == 16'd0)
            w_state_next = DONE;
          else if (w_len_full > 16'(DEPTH_WORDS))
            w_state_next = ERR;
          else
            w_state_next = DATA;
        end
      end
      DATA: begin
        byte_ready = 1'b1;
        if (w_word_valid && (r_word_idx == r_len - 16'd1))
          w_state_next = FLUSH;
      end
      FLUSH: begin
        w_state_next = DONE;
      end
      DONE: begin
        done    = 1'b1;
        cpu_rst = 1'b0;
        if (start) w_state_next = LEN_LO;
      end
      ERR: begin
        err = 1'b1;
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  // Write port is registered so the stream never stalls on a word boundary;
  // address/data hold their last values between strobes.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_len       <= 16'd0;
      r_word_idx  <= 16'd0;
      r_mem_we    <= 1'b0;
      r_mem_waddr <= '0;
      r_mem_wdata <= 32'd0;
    end else begin
      r_mem_we <= w_word_valid;
      if (r_state == LEN_LO && w_accept) r_len[7:0]  <= byte_data;
      if (r_state == LEN_HI && w_accept) r_len[15:8] <= byte_data;
      if (w_load_start) begin
        r_word_idx <= 16'd0;
      end else if (w_word_valid) begin
        r_word_idx  <= r_word_idx + 16'd1;
        r_mem_waddr <= ADDR_W'({r_word_idx, 2'b00});
        r_mem_wdata <= w_word;
      end
    end
  end

  assign mem_we    = r_mem_we;
  assign mem_waddr = r_mem_waddr;
  assign mem_wdata = r_mem_wdata;

endmodule

// File: tb/tb_inst_mem_loader.sv
module tb_inst_mem_loader;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        start = 1'b0;
  logic        byte_valid = 1'b0;
  logic [7:0]  byte_data = 8'h00;
  logic        byte_ready, mem_we, cpu_rst, done, err;
  logic [31:0] mem_waddr, mem_wdata;

  int n_checks = 0;
  int n_errors = 0;

  always #5 CLK = ~CLK;

  inst_mem_loader #(.DEPTH_WORDS(64), .ADDR_W(32)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .start      (start),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .byte_ready (byte_ready),
    .mem_we     (mem_we),
    .mem_waddr  (mem_waddr),
    .mem_wdata  (mem_wdata),
    .cpu_rst    (cpu_rst),
    .done       (done),
    .err        (err)
  );

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;
  wr_t wr_log[$];

  always @(negedge CLK) begin
    if (mem_we) wr_log.push_back('{addr: mem_waddr, data: mem_wdata});
  end

  typedef struct {
    logic        start;
    logic        bv;
    logic [7:0]  bd;
    logic        ready;
    logic        we;
    logic        done;
    logic        cpu_rst;
    logic [31:0] addr;
    logic [31:0] data;
  } vec_t;
  vec_t vecs[13];

  function automatic vec_t mk(input logic s, input logic v, input logic [7:0] d,
                              input logic r, input logic w, input logic dn,
                              input logic cr, input logic [31:0] a, input logic [31:0] dt);
    vec_t t;
    t.start = s; t.bv = v; t.bd = d; t.ready = r; t.we = w;
    t.done = dn; t.cpu_rst = cr; t.addr = a; t.data = dt;
    return t;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step(input logic s, input logic v, input logic [7:0] d);
    start = s; byte_valid = v; byte_data = d;
    @(posedge CLK);
    #1;
    start = 1'b0; byte_valid = 1'b0;
  endtask

  task automatic send(input logic [7:0] d);
    step(1'b0, 1'b1, d);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 8'hFF);
  endtask

  initial begin
    // Two-word load, checked cycle by cycle (outputs sampled 1ns after the edge).
    vecs[0]  = mk(1, 0, 8'h00, 1, 0, 0, 1, 32'h0, 32'h0);
    vecs[1]  = mk(0, 1, 8'h02, 1, 0, 0, 1, 32'h0, 32'h0);
    vecs[2]  = mk(0, 1, 8'h00, 1, 0, 0, 1, 32'h0, 32'h0);
    vecs[3]  = mk(0, 1, 8'h33, 1, 0, 0, 1, 32'h0, 32'h0);
    vecs[4]  = mk(0, 1, 8'h01, 1, 0, 0, 1, 32'h0, 32'h0);
    vecs[5]  = mk(0, 1, 8'h00, 1, 0, 0, 1, 32'h0, 32'h0);
    vecs[6]  = mk(0, 1, 8'h00, 1, 1, 0, 1, 32'h0, 32'h00000133);
    vecs[7]  = mk(0, 1, 8'hB3, 1, 0, 0, 1, 32'h0, 32'h00000133);
    vecs[8]  = mk(0, 1, 8'h02, 1, 0, 0, 1, 32'h0, 32'h00000133);
    vecs[9]  = mk(0, 1, 8'h00, 1, 0, 0, 1, 32'h0, 32'h00000133);
    vecs[10] = mk(0, 1, 8'h00, 0, 1, 0, 1, 32'h4, 32'h000002B3);
    vecs[11] = mk(0, 0, 8'h00, 0, 0, 1, 0, 32'h4, 32'h000002B3);
    vecs[12] = mk(0, 0, 8'h00, 0, 0, 1, 0, 32'h4, 32'h000002B3);

    // Reset then idle
    RST = 1'b1;
    idle(2);
    check("rst_cpu_rst", cpu_rst, 1);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    check("rst_ready", byte_ready, 0);
    check("rst_waddr", mem_waddr, 0);
    check("rst_wdata", mem_wdata, 0);
    RST = 1'b0;
    idle(3);
    check("idle_ready", byte_ready, 0);
    check("idle_cpu_rst", cpu_rst, 1);
    check("idle_no_we", wr_log.size(), 0);

    // Table-driven two-word load
    for (int i = 0; i < 13; i++) begin
      step(vecs[i].start, vecs[i].bv, vecs[i].bd);
      check($sformatf("v%0d_ready", i), byte_ready, vecs[i].ready);
      check($sformatf("v%0d_we", i), mem_we, vecs[i].we);
      check($sformatf("v%0d_done", i), done, vecs[i].done);
      check($sformatf("v%0d_cpu_rst", i), cpu_rst, vecs[i].cpu_rst);
      check($sformatf("v%0d_err", i), err, 0);
      check($sformatf("v%0d_addr", i), mem_waddr, vecs[i].addr);
      check($sformatf("v%0d_data", i), mem_wdata, vecs[i].data);
      $display("vector %0d: ready=%b we=%b addr=%h data=%h done=%b", i, byte_ready, mem_we, mem_waddr, mem_wdata, done);
    end
    check("load_nwrites", wr_log.size(), 2);

    // Bytes offered while in DONE are ignored
    send(8'hAA);
    check("done_ignore_ready", byte_ready, 0);
    check("done_hold", done, 1);

    // Stalled stream: 3 idle cycles mid-word
    wr_log.delete();
    step(1, 0, 8'h00);
    check("restart_done", done, 0);
    check("restart_cpu_rst", cpu_rst, 1);
    send(8'h02); send(8'h00); send(8'h33); send(8'h01);
    idle(3);
    send(8'h00); send(8'h00);
    send(8'hB3); send(8'h02); send(8'h00); send(8'h00);
    idle(1);
    check("stall_nwrites", wr_log.size(), 2);
    if (wr_log.size() == 2) begin
      check("stall_w0_addr", wr_log[0].addr, 32'h0);
      check("stall_w0_data", wr_log[0].data, 32'h00000133);
      check("stall_w1_addr", wr_log[1].addr, 32'h4);
      check("stall_w1_data", wr_log[1].data, 32'h000002B3);
    end
    check("stall_done", done, 1);
    $display("stalled load: %0d writes, done=%b", wr_log.size(), done);

    // Zero length
    wr_log.delete();
    step(1, 0, 8'h00);
    send(8'h00);
    send(8'h00);
    check("zero_done", done, 1);
    check("zero_cpu_rst", cpu_rst, 0);
    idle(2);
    check("zero_nwrites", wr_log.size(), 0);
    $display("zero-length load: done=%b writes=%0d", done, wr_log.size());

    // Overflow: 65 words
    wr_log.delete();
    step(1, 0, 8'h00);
    send(8'h41);
    send(8'h00);
    check("ovf_err", err, 1);
    check("ovf_ready", byte_ready, 0);
    check("ovf_cpu_rst", cpu_rst, 1);
    check("ovf_done", done, 0);
    send(8'h11); send(8'h22); send(8'h33); send(8'h44);
    step(1, 0, 8'h00);
    idle(2);
    check("ovf_sticky_err", err, 1);
    check("ovf_sticky_ready", byte_ready, 0);
    check("ovf_nwrites", wr_log.size(), 0);
    RST = 1'b1;
    idle(1);
    RST = 1'b0;
    check("ovf_rst_err", err, 0);
    check("ovf_rst_cpu_rst", cpu_rst, 1);
    $display("overflow: err cleared by reset, writes=%0d", wr_log.size());

    // Reset mid-load, then fresh load from address 0
    wr_log.delete();
    step(1, 0, 8'h00);
    send(8'h02); send(8'h00);
    send(8'hAA); send(8'hBB);
    RST = 1'b1;
    idle(1);
    RST = 1'b0;
    check("midrst_ready", byte_ready, 0);
    check("midrst_cpu_rst", cpu_rst, 1);
    check("midrst_done", done, 0);
    step(1, 0, 8'h00);
    send(8'h01); send(8'h00);
    send(8'h11); send(8'h22); send(8'h33); send(8'h44);
    idle(1);
    check("reload_nwrites", wr_log.size(), 1);
    if (wr_log.size() == 1) begin
      check("reload_addr", wr_log[0].addr, 32'h0);
      check("reload_data", wr_log[0].data, 32'h44332211);
    end
    check("reload_done", done, 1);
    check("reload_cpu_rst", cpu_rst, 0);
    $display("reload after reset: %0d writes, done=%b", wr_log.size(), done);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/inst_mem_loader.md
Name: inst_mem_loader

Overview:
- Write-side counterpart of the single-cycle CPU's instruction fetch path; the CPU reads words from instruction memory, this block fills that memory.
- Receives a byte stream over a valid/ready interface, packs little-endian bytes into 32-bit instruction words, and issues word writes at byte addresses 0, 4, 8, ...
- Holds the CPU in reset (cpu_rst) until the image has been written.

Parameters:
- DEPTH_WORDS, 64, instruction memory capacity in 32-bit words; the maximum accepted word count.
- ADDR_W, 32, width of mem_waddr; matches the CPU fetch address width.

Ports:
- CLK  input  1  clock; all state changes on the rising edge.
- RST  input  1  synchronous, active-high reset.
- start  input  1  one-cycle pulse; begins a load when in IDLE or DONE.
- byte_valid  input  1  byte_data holds a valid byte.
- byte_data  input  8  stream byte.
- byte_ready  output  1  loader accepts a byte this cycle.
- mem_we  output  1  one-cycle write strobe to instruction memory.
- mem_waddr  output  ADDR_W  byte address, always word aligned (bits [1:0] = 0).
- mem_wdata  output  32  instruction word.
- cpu_rst  output  1  high holds the CPU in reset.
- done  output  1  image fully written; held until the next start or RST.
- err  output  1  length exceeds DEPTH_WORDS; sticky until RST.

Behaviour:
- Reset (RST high at an edge): state IDLE; byte_ready=0, mem_we=0, mem_waddr=0, mem_wdata=0, done=0, err=0, cpu_rst=1; byte counter and word counter cleared. RST overrides every state, including mid-load.
- Handshake: a byte is accepted only when byte_valid && byte_ready at a rising edge. While byte_ready=0, bytes are ignored and not buffered.
- Stream format: LEN_LO, LEN_HI (16-bit word count N, little endian), then 4*N data bytes. Each word is sent least-significant byte first.
- States:
  - IDLE: byte_ready=0, cpu_rst=1. start -> LEN_LO.
  - LEN_LO: byte_ready=1. On accept, latch N[7:0] -> LEN_HI.
  - LEN_HI: byte_ready=1. On accept, latch N[15:8], then:
    - N==0 -> DONE.
    - N>DEPTH_WORDS -> ERR.
    - otherwise -> DATA.
  - DATA: byte_ready=1. Byte k (k=0..3) goes into word bits [8k+7:8k]. On accepting byte 3:
    - next cycle mem_we=1, mem_wdata = the assembled word, mem_waddr = word_idx*4; word_idx increments.
    - if this was word N-1, go to FLUSH (byte_ready=0); else stay in DATA with byte counter back to 0.
  - The write strobe is registered, so byte_ready stays high in DATA with no stalls. Back-to-back words give mem_we on consecutive 4-byte boundaries.
  - FLUSH: exactly one cycle, during which the final mem_we pulse is visible -> DONE.
  - DONE: done=1, cpu_rst=0, byte_ready=0. start -> LEN_LO, with done=0, cpu_rst=1, counters cleared on the same edge.
  - ERR: err=1, cpu_rst=1, byte_ready=0, no writes; exit only via RST.
- mem_we is high for exactly one cycle per word and never high outside DATA/FLUSH. mem_waddr and mem_wdata hold their last values when mem_we=0.
- start is ignored in LEN_LO, LEN_HI, DATA, FLUSH and ERR.
- start and an accepted byte never coincide, because byte_ready=0 in IDLE/DONE.
- A partial word left when the stream stops is held indefinitely; no timeout.
- Latency: final byte accepted at edge t -> mem_we high in cycle t..t+1 -> done=1 and cpu_rst=0 after edge t+1.

Decomposition:
- Shared package inst_loader_pkg:
  - state enum: IDLE, LEN_LO, LEN_HI, DATA, FLUSH, DONE, ERR.
  - constants: WORD_BYTES=4, LEN_BYTES=2.
- One sub-module, byte_word_packer: 2-bit byte counter plus a 24-bit shift register. Outputs word_valid and a 32-bit word on the 4th accepted byte; has a synchronous clear input.

Test Plan:
- Reset, then idle: RST high 2 cycles -> cpu_rst=1, done=0, err=0, byte_ready=0, mem_we never pulses.
- Two-word load: start; bytes 02 00 | 33 01 00 00 | B3 02 00 00.
  - -> mem_we@0x0 data 0x00000133; mem_we@0x4 data 0x000002B3.
  - -> done=1 and cpu_rst=0 exactly one cycle after the second strobe.
- Stalled stream: same image with byte_valid low for 3 cycles mid-word -> identical writes, no extra mem_we, word assembly unaffected.
- Zero length: bytes 00 00 -> no mem_we, done=1 one cycle after LEN_HI is accepted.
- Overflow: DEPTH_WORDS=64, length bytes 41 00 (65 words) -> err=1, byte_ready=0, cpu_rst=1. Subsequent bytes and start ignored until RST.
- Reset mid-load: assert RST after byte 2 of word 1 -> next cycle IDLE, cpu_rst=1, done=0. A fresh start then reloads from address 0x0 correctly.
